// File: rtl/io_pkg.sv
// Shared constants for the CPU I/O mailbox: I/O window address and the
// status word bit map.
package io_pkg;

  localparam logic [15:0] IO_ADDR = 16'hfffe;

  // Status word single-bit flags.
  localparam int ST_RX_NE   = 0;
  localparam int ST_TX_FULL = 1;
  localparam int ST_TX_OVF  = 2;
  localparam int ST_RX_UNF  = 3;

  // Status word 4-bit count fields.
  localparam int ST_RXCNT_LSB = 4;
  localparam int ST_TXCNT_LSB = 8;

  // Sticky flag update: a set event in the same cycle as a clear wins.
  function automatic logic sticky_next(input logic q, input logic set, input logic clr);
    if (set)      return 1'b1;
    else if (clr) return 1'b0;
    else          return q;
  endfunction

endpackage

// File: rtl/io_fifo.sv
// Small synchronous FIFO. Pop while empty is ignored; push while full is
// ignored unless a pop happens in the same cycle. Storage is not reset.
module io_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    push_i,
  input  logic                    pop_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic [$clog2(DEPTH):0]  count_o,
  output logic                    full_o,
  output logic                    empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [DATA_WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]         count_q, count_d;
  logic                  do_push, do_pop;

  // Qualify push/pop and compute next pointers and count.
  always_comb begin
    do_pop   = pop_i && (count_q != '0);
    do_push  = push_i && ((count_q != CW'(DEPTH)) || do_pop);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) wr_ptr_d = wr_ptr_q + PW'(1);
    if (do_pop)  rd_ptr_d = rd_ptr_q + PW'(1);
    case ({do_push, do_pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Pointer and count registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage write; contents survive reset, only the pointers are cleared.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

  assign rdata_o = mem_q[rd_ptr_q];
  assign count_o = count_q;
  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

endmodule

// File: rtl/io_mailbox.sv
// CPU I/O window mailbox: CPU stores go out to the device through a TX FIFO,
// device words come back through an RX FIFO and are read at IOIn.
// Device-side channels use valid/ready: a word moves on a clock edge where
// valid and ready are both high; the sender holds data stable while valid is
// high and ready is low. All outputs come from registered state only.
module io_mailbox
  import io_pkg::*;
#(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 16
) (
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic [DATA_WIDTH-1:0] IOOut,
  input  logic                  IOOutStrobe,
  input  logic                  IOReadAck,
  input  logic                  IOStatusClear,
  output logic [DATA_WIDTH-1:0] IOIn,
  output logic [15:0]           IOStatus,
  output logic [DATA_WIDTH-1:0] DevOutData,
  output logic                  DevOutValid,
  input  logic                  DevOutReady,
  input  logic [DATA_WIDTH-1:0] DevInData,
  input  logic                  DevInValid,
  output logic                  DevInReady
);

  localparam int CW = $clog2(DEPTH) + 1;

  logic [DATA_WIDTH-1:0] rx_rdata;
  logic [CW-1:0]         tx_count, rx_count;
  logic                  tx_full, tx_empty, rx_full, rx_empty;
  logic                  tx_push, tx_pop, rx_push, rx_pop;
  logic                  ovf_set, unf_set;
  logic                  tx_ovf_q, tx_ovf_d, rx_unf_q, rx_unf_d;

  // Handshake qualification and sticky error events.
  always_comb begin
    tx_pop   = !tx_empty && DevOutReady;
    tx_push  = IOOutStrobe && (!tx_full || tx_pop);
    ovf_set  = IOOutStrobe && tx_full && !tx_pop;
    rx_push  = DevInValid && !rx_full;
    rx_pop   = IOReadAck && !rx_empty;
    unf_set  = IOReadAck && rx_empty;
    tx_ovf_d = sticky_next(tx_ovf_q, ovf_set, IOStatusClear);
    rx_unf_d = sticky_next(rx_unf_q, unf_set, IOStatusClear);
  end

  // Sticky error flag registers.
  always_ff @(posedge CLK) begin
    if (Reset) begin
      tx_ovf_q <= 1'b0;
      rx_unf_q <= 1'b0;
    end else begin
      tx_ovf_q <= tx_ovf_d;
      rx_unf_q <= rx_unf_d;
    end
  end

  io_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_tx_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (tx_push),
    .pop_i   (tx_pop),
    .wdata_i (IOOut),
    .rdata_o (DevOutData),
    .count_o (tx_count),
    .full_o  (tx_full),
    .empty_o (tx_empty)
  );

  io_fifo #(.DEPTH(DEPTH), .DATA_WIDTH(DATA_WIDTH)) u_rx_fifo (
    .clk_i   (CLK),
    .rst_i   (Reset),
    .push_i  (rx_push),
    .pop_i   (rx_pop),
    .wdata_i (DevInData),
    .rdata_o (rx_rdata),
    .count_o (rx_count),
    .full_o  (rx_full),
    .empty_o (rx_empty)
  );

  // Status packing and CPU-visible read data (zero when RX is empty).
  always_comb begin
    IOStatus                        = '0;
    IOStatus[ST_RX_NE]              = !rx_empty;
    IOStatus[ST_TX_FULL]            = tx_full;
    IOStatus[ST_TX_OVF]             = tx_ovf_q;
    IOStatus[ST_RX_UNF]             = rx_unf_q;
    IOStatus[ST_RXCNT_LSB +: 4]     = 4'(rx_count);
    IOStatus[ST_TXCNT_LSB +: 4]     = 4'(tx_count);
    IOIn                            = rx_empty ? '0 : rx_rdata;
  end

  assign DevOutValid = !tx_empty;
  assign DevInReady  = !rx_full;

endmodule

// File: tb/tb_io_mailbox.sv
// Bench for io_mailbox: directed scenarios followed by random traffic,
// checked against a queue-based reference model.
module tb_io_mailbox;

  localparam int DEPTH = 4;
  localparam int W     = 16;

  // Clock / reset
  logic         CLK = 1'b0;
  logic         Reset = 1'b1;
  logic [W-1:0] IOOut = '0;
  logic         IOOutStrobe = 1'b0;
  logic         IOReadAck = 1'b0;
  logic         IOStatusClear = 1'b0;
  logic [W-1:0] IOIn;
  logic [15:0]  IOStatus;
  logic [W-1:0] DevOutData;
  logic         DevOutValid;
  logic         DevOutReady = 1'b0;
  logic [W-1:0] DevInData = '0;
  logic         DevInValid = 1'b0;
  logic         DevInReady;

  always #5 CLK = ~CLK;

  io_mailbox #(.DEPTH(DEPTH), .DATA_WIDTH(W)) dut (
    .CLK           (CLK),
    .Reset         (Reset),
    .IOOut         (IOOut),
    .IOOutStrobe   (IOOutStrobe),
    .IOReadAck     (IOReadAck),
    .IOStatusClear (IOStatusClear),
    .IOIn          (IOIn),
    .IOStatus      (IOStatus),
    .DevOutData    (DevOutData),
    .DevOutValid   (DevOutValid),
    .DevOutReady   (DevOutReady),
    .DevInData     (DevInData),
    .DevInValid    (DevInValid),
    .DevInReady    (DevInReady)
  );

  // Reference model: FIFO contents as queues, sticky flags as bits.
  logic [W-1:0] exp_tx_q[$];
  logic [W-1:0] exp_rx_q[$];
  bit           m_ovf = 1'b0;
  bit           m_unf = 1'b0;
  bit           checking = 1'b0;
  int           vectors = 0;
  int           miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] model_status();
    logic [15:0] s;
    s        = '0;
    s[0]     = (exp_rx_q.size() != 0);
    s[1]     = (exp_tx_q.size() == DEPTH);
    s[2]     = m_ovf;
    s[3]     = m_unf;
    s[7:4]   = 4'(exp_rx_q.size());
    s[11:8]  = 4'(exp_tx_q.size());
    return s;
  endfunction

  // Monitor: mid-cycle, compare outputs with the model and retire words the
  // coming edge will hand over.
  always @(negedge CLK) begin
    if (checking && !Reset) begin
      check("status", 32'(IOStatus), 32'(model_status()));
      check("dev_out_valid", 32'(DevOutValid), 32'(exp_tx_q.size() > 0));
      check("dev_in_ready", 32'(DevInReady), 32'(exp_rx_q.size() < DEPTH));
      if (exp_rx_q.size() > 0) check("io_in", 32'(IOIn), 32'(exp_rx_q[0]));
      else                     check("io_in_empty", 32'(IOIn), 32'(0));
      if (DevOutReady && exp_tx_q.size() > 0) begin
        check("dev_out_data", 32'(DevOutData), 32'(exp_tx_q[0]));
        void'(exp_tx_q.pop_front());
      end
      if (IOReadAck && exp_rx_q.size() > 0) void'(exp_rx_q.pop_front());
    end
  end

  // Driver: apply one cycle of inputs, predict its effect, commit after the edge.
  task automatic cyc(input bit stb, input logic [W-1:0] w, input bit dr, input bit ack,
                     input bit clr, input bit dv, input logic [W-1:0] dd, input bit rst);
    int tc, rc;
    bit p_tx, p_rx, p_ovf, p_unf;
    IOOutStrobe = stb; IOOut = w; DevOutReady = dr; IOReadAck = ack;
    IOStatusClear = clr; DevInValid = dv; DevInData = dd; Reset = rst;
    tc    = exp_tx_q.size();
    rc    = exp_rx_q.size();
    p_tx  = stb && (tc < DEPTH || (tc > 0 && dr));
    p_ovf = stb && !p_tx;
    p_rx  = dv && (rc < DEPTH);
    p_unf = ack && (rc == 0);
    @(posedge CLK);
    #1;
    if (rst) begin
      exp_tx_q.delete();
      exp_rx_q.delete();
      m_ovf = 1'b0;
      m_unf = 1'b0;
    end else begin
      if (p_tx) exp_tx_q.push_back(w);
      if (p_rx) exp_rx_q.push_back(dd);
      m_ovf = p_ovf ? 1'b1 : (clr ? 1'b0 : m_ovf);
      m_unf = p_unf ? 1'b1 : (clr ? 1'b0 : m_unf);
    end
  endtask

  task automatic idle(input bit dr);
    cyc(0, '0, dr, 0, 0, 0, '0, 0);
  endtask

  initial begin
    bit           stb, dr, ack, clr, dv, rst, hold;
    logic [W-1:0] dd;

    // Reset, then idle
    cyc(0, '0, 0, 0, 0, 0, '0, 1);
    cyc(0, '0, 0, 0, 0, 0, '0, 1);
    checking = 1'b1;
    idle(0);
    check("reset_status", 32'(IOStatus), 32'h0000);
    check("reset_in_ready", 32'(DevInReady), 32'd1);
    check("reset_out_valid", 32'(DevOutValid), 32'd0);
    check("reset_io_in", 32'(IOIn), 32'h0000);

    // Two words out, then release ready
    cyc(1, 16'h1234, 0, 0, 0, 0, '0, 0);
    cyc(1, 16'h5678, 0, 0, 0, 0, '0, 0);
    check("tx_cnt_2", 32'(IOStatus[11:8]), 32'd2);
    check("tx_head_1234", 32'(DevOutData), 32'h1234);
    idle(1);
    check("tx_cnt_1", 32'(IOStatus[11:8]), 32'd1);
    check("tx_head_5678", 32'(DevOutData), 32'h5678);
    idle(1);
    check("tx_cnt_0", 32'(IOStatus[11:8]), 32'd0);

    // Overflow: five strobes into a four-deep FIFO
    for (int i = 1; i <= 5; i++) cyc(1, W'(i), 0, 0, 0, 0, '0, 0);
    check("tx_ovf_status", 32'(IOStatus), 32'h0406);
    for (int i = 0; i < 4; i++) idle(1);
    cyc(0, '0, 0, 0, 1, 0, '0, 0);
    check("ovf_cleared", 32'(IOStatus[2]), 32'd0);

    // RX path and underflow
    cyc(0, '0, 0, 0, 0, 1, 16'hAAAA, 0);
    cyc(0, '0, 0, 0, 0, 1, 16'hBBBB, 0);
    check("rx_head_aaaa", 32'(IOIn), 32'hAAAA);
    check("rx_cnt_2", 32'(IOStatus[7:4]), 32'd2);
    cyc(0, '0, 0, 1, 0, 0, '0, 0);
    check("rx_head_bbbb", 32'(IOIn), 32'hBBBB);
    cyc(0, '0, 0, 1, 0, 0, '0, 0);
    check("rx_empty_zero", 32'(IOIn), 32'h0000);
    cyc(0, '0, 0, 1, 0, 0, '0, 0);
    check("rx_unf_set", 32'(IOStatus[3]), 32'd1);
    cyc(0, '0, 0, 0, 1, 0, '0, 0);

    // Full TX with simultaneous strobe and pop; full RX back-pressure
    for (int i = 0; i < 4; i++) cyc(1, W'(16'h10 + i), 0, 0, 0, 0, '0, 0);
    cyc(1, 16'h0014, 1, 0, 0, 0, '0, 0);
    check("tx_full_swap_cnt", 32'(IOStatus[11:8]), 32'd4);
    check("tx_full_swap_ovf", 32'(IOStatus[2]), 32'd0);
    for (int i = 0; i < 4; i++) idle(1);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 0, 0, 1, W'(16'h20 + i), 0);
    check("rx_full_ready", 32'(DevInReady), 32'd0);
    cyc(0, '0, 0, 0, 0, 1, 16'h0024, 0);
    check("rx_full_cnt", 32'(IOStatus[7:4]), 32'd4);
    for (int i = 0; i < 4; i++) cyc(0, '0, 0, 1, 0, 0, '0, 0);

    // Reset with both FIFOs holding three words and a sticky bit set
    cyc(0, '0, 0, 1, 0, 0, '0, 0);
    for (int i = 0; i < 3; i++) cyc(1, W'(16'h30 + i), 0, 0, 0, 1, W'(16'h40 + i), 0);
    cyc(1, 16'h0099, 1, 1, 0, 1, 16'h0098, 1);
    check("rst_status", 32'(IOStatus), 32'h0000);
    check("rst_io_in", 32'(IOIn), 32'h0000);
    check("rst_out_valid", 32'(DevOutValid), 32'd0);
    check("rst_in_ready", 32'(DevInReady), 32'd1);

    // Random traffic; the device holds its word while stalled
    hold = 1'b0;
    dd   = '0;
    for (int n = 0; n < 3000; n++) begin
      stb = ($urandom_range(0, 1) == 1);
      dr  = ($urandom_range(0, 2) != 0);
      ack = ($urandom_range(0, 2) == 0);
      clr = ($urandom_range(0, 15) == 0);
      rst = ($urandom_range(0, 249) == 0);
      if (hold) dv = 1'b1;
      else begin
        dv = ($urandom_range(0, 1) == 1);
        dd = W'($urandom);
      end
      hold = dv && !rst && (exp_rx_q.size() >= DEPTH);
      cyc(stb, W'($urandom), dr, ack, clr, dv, dd, rst);
    end
    idle(0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/io_mailbox.md
# io_mailbox

Memory-mapped I/O peripheral on the device side of the accumulator CPU's I/O window. Takes the 16-bit words the CPU stores to the I/O address and hands them to an external device over a valid/ready channel. Accepts words from the device over a second valid/ready channel and presents them to the CPU as the value returned by a load from the I/O address. Both directions are buffered in small FIFOs, and a status word reports occupancy and error flags.

## Interface
Parameters:
- DEPTH, 4, entries per FIFO; power of two, 2..8
- DATA_WIDTH, 16, word width

Ports:
- CLK  in  1  clock
- Reset  in  1  reset, synchronous, active-high
- IOOut  in  16  word the CPU is storing to the I/O address
- IOOutStrobe  in  1  one-cycle pulse: CPU store to I/O address this cycle
- IOReadAck  in  1  one-cycle pulse: CPU consumed IOIn this cycle
- IOStatusClear  in  1  pulse: clear sticky error bits
- IOIn  out  16  head of RX FIFO; 16'h0000 when RX empty
- IOStatus  out  16  status word, bit map below
- DevOutData  out  16  head of TX FIFO
- DevOutValid  out  1  TX FIFO non-empty
- DevOutReady  in  1  device accepts DevOutData
- DevInData  in  16  word from device
- DevInValid  in  1  device offers DevInData
- DevInReady  out  1  RX FIFO not full

## Operation
- TX push: IOOutStrobe=1 and (tx_count<DEPTH, or a TX pop in the same cycle) writes IOOut at the tail.
  - A strobe while full with no simultaneous pop drops the word and sets tx_ovf.
- TX pop: DevOutValid & DevOutReady advances the head.
- RX push: DevInValid & DevInReady writes DevInData at the tail.
  - DevInReady = (rx_count<DEPTH). It depends on registered state only, with no combinational path from IOReadAck.
- RX pop: IOReadAck with rx_count>0 advances the head.
  - IOReadAck while empty sets rx_unf and changes nothing else.
- Simultaneous push and pop on one FIFO: count unchanged, both pointers advance.
- Pointers: log2(DEPTH) bits, wrap modulo DEPTH. Counts: log2(DEPTH)+1 bits, saturating at 0 and DEPTH by construction.
- IOStatus bit map:
  - [0] rx_count!=0
  - [1] tx_count==DEPTH
  - [2] tx_ovf, sticky
  - [3] rx_unf, sticky
  - [7:4] rx_count
  - [11:8] tx_count
  - [15:12] 0
- Sticky bits are cleared by IOStatusClear. If clear and a set event occur in the same cycle, set wins.

## Timing
- Reset (synchronous): pointers and counts → 0, tx_ovf = rx_unf = 0. FIFO storage is not cleared.
- Outputs after reset: IOIn=0, IOStatus=0, DevOutValid=0, DevInReady=1. DevOutData is don't-care while DevOutValid=0.
- Reset asserted mid-transfer: all in-flight words are discarded. Reset has priority over every other input in that cycle.
- Latency:
  - Strobe at edge n → DevOutValid=1 and DevOutData=word after edge n, when TX was empty.
  - Device push at edge n → IOIn valid and IOStatus[0]=1 after edge n.
- IOIn, DevOutData, DevOutValid, DevInReady and IOStatus are functions of registered state only. No input-to-output combinational paths.
- Device-side handshake: DevOutData is stable while DevOutValid=1 and DevOutReady=0. The device must hold DevInData while DevInValid=1 and DevInReady=0.

## Structure
- Shared package io_pkg holds:
  - IO_ADDR = 16'hfffe
  - status bit indices: ST_RX_NE=0, ST_TX_FULL=1, ST_TX_OVF=2, ST_RX_UNF=3
  - field LSBs: ST_RXCNT_LSB=4, ST_TXCNT_LSB=8
- Sub-module io_fifo (DEPTH, DATA_WIDTH; push, pop, wdata, rdata, count, full, empty) is instantiated twice, once for TX and once for RX.
  - Inside io_fifo: pop while empty is ignored. Push while full is ignored unless a pop happens in the same cycle.
- io_mailbox owns the strobe qualification, the sticky flags, IOIn zeroing and the status packing.

## Test plan
- Reset, then idle → IOStatus=16'h0000, DevInReady=1, DevOutValid=0, IOIn=0.
- Strobe 16'h1234, 16'h5678 with DevOutReady=0, then raise ready → DevOutData 1234 then 5678 on consecutive cycles. IOStatus[11:8] goes 2→1→0.
- Five strobes with DEPTH=4 and ready=0 → fifth dropped, IOStatus=16'h0406 (tx_count=4, full, ovf). Then drain → four words 1..4 in order. IOStatusClear → bit2=0.
- Device pushes 16'hAAAA, 16'hBBBB → IOIn=AAAA and IOStatus[7:4]=2. IOReadAck → IOIn=BBBB. Second IOReadAck → IOIn=0. Third IOReadAck → IOStatus[3]=1.
- TX full plus strobe and DevOutReady in the same cycle → new word accepted, tx_count stays 4, no ovf. RX full → DevInReady=0 and DevInValid is ignored until an IOReadAck.
- Reset asserted with both FIFOs holding 3 words → next cycle all counts 0, IOIn=0, DevOutValid=0, sticky bits 0.
